// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Imported by serial_subtractor; holds the FSM state type and default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of a - b - borrow-in.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: o_diff = i_a - i_b, one bit per cycle, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output o_ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             o_borrow,
    output logic             o_ovf
`else
    output logic             o_borrow
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic               r_aMsb;
    logic               r_bMsb;
`endif

    logic               w_diff;
    logic               w_bout;

    full_subtractor u_fs (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    // Operands shift out from the LSB while result bits enter at the MSB,
    // so after WIDTH shifts bit k of the difference lands at r_res[k].
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_aMsb   <= 1'b0;
            r_bMsb   <= 1'b0;
            o_ovf    <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        o_busy   <= 1'b1;
                        r_state  <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        r_aMsb   <= i_a[WIDTH-1];
                        r_bMsb   <= i_b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= (r_res >> 1) | (WIDTH'(w_diff) << (WIDTH - 1));
                    r_borrow <= w_bout;
                    // Counter ends at WIDTH, which still fits, so it never wraps.
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        o_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    o_done   <= 1'b1;
                    o_diff   <= r_res;
                    o_borrow <= r_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    o_ovf    <= (r_aMsb != r_bMsb) && (r_res[WIDTH-1] != r_aMsb);
`endif
                    r_state  <= IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances checked every cycle
// against an arithmetic model, plus directed cases with literal expectations.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rstN;
    logic startIn [2];
    logic [7:0] aIn [2];
    logic [7:0] bIn [2];

    logic       busy0, done0, borrow0;
    logic [7:0] diff0;
    logic       busy1, done1, borrow1;
    logic [0:0] diff1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       ovf0, ovf1;
`endif

    int wArr [2] = '{8, 1};

    int         age [2];
    logic [7:0] pendDiff [2];
    logic       pendBorrow [2];
    logic       pendOvf [2];
    logic       eBusy [2];
    logic       eDone [2];
    logic [7:0] eDiff [2];
    logic       eBorrow [2];
    logic       eOvf [2];

    int checks = 0;
    int passes = 0;
    bit running = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .i_clk    (clk),
        .i_rst_n  (rstN),
        .i_start  (startIn[0]),
        .i_a      (aIn[0]),
        .i_b      (bIn[0]),
        .o_busy   (busy0),
        .o_done   (done0),
        .o_diff   (diff0),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .o_borrow (borrow0),
        .o_ovf    (ovf0)
`else
        .o_borrow (borrow0)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .i_clk    (clk),
        .i_rst_n  (rstN),
        .i_start  (startIn[1]),
        .i_a      (aIn[1][0]),
        .i_b      (bIn[1][0]),
        .o_busy   (busy1),
        .o_done   (done1),
        .o_diff   (diff1),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .o_borrow (borrow1),
        .o_ovf    (ovf1)
`else
        .o_borrow (borrow1)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: an accepted operation yields a-b mod 2^W, borrow when a<b, and a
    // signed-range overflow flag; busy for W cycles and done W+1 edges after acceptance.
    always @(posedge clk or negedge rstN) begin : model
        longint m, ua, ub, sa, sb, sres, half;
        if (!rstN) begin
            for (int d = 0; d < 2; d++) begin
                age[d] = -1;
                eBusy[d] = 1'b0; eDone[d] = 1'b0; eDiff[d] = '0;
                eBorrow[d] = 1'b0; eOvf[d] = 1'b0;
                pendDiff[d] = '0; pendBorrow[d] = 1'b0; pendOvf[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m    = (64'sd1 << wArr[d]) - 1;
                half = 64'sd1 << (wArr[d] - 1);
                if (age[d] < 0 || age[d] == wArr[d] + 1) begin
                    if (startIn[d]) begin
                        age[d] = 0;
                        ua = longint'(aIn[d]) & m;
                        ub = longint'(bIn[d]) & m;
                        pendDiff[d]   = 8'((ua - ub) & m);
                        pendBorrow[d] = (ua < ub);
                        sa   = (ua >= half) ? ua - (m + 1) : ua;
                        sb   = (ub >= half) ? ub - (m + 1) : ub;
                        sres = sa - sb;
                        pendOvf[d] = (sres < -half) || (sres > half - 1);
                    end else begin
                        age[d] = -1;
                    end
                end else begin
                    age[d]++;
                end
                eBusy[d] = (age[d] >= 0) && (age[d] < wArr[d]);
                eDone[d] = (age[d] == wArr[d] + 1);
                if (eDone[d]) begin
                    eDiff[d]   = pendDiff[d];
                    eBorrow[d] = pendBorrow[d];
                    eOvf[d]    = pendOvf[d];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            checkOutput("busy8",   busy0,   eBusy[0]);
            checkOutput("done8",   done0,   eDone[0]);
            checkOutput("diff8",   diff0,   eDiff[0]);
            checkOutput("borrow8", borrow0, eBorrow[0]);
            checkOutput("busy1",   busy1,   eBusy[1]);
            checkOutput("done1",   done1,   eDone[1]);
            checkOutput("diff1",   diff1,   eDiff[1][0]);
            checkOutput("borrow1", borrow1, eBorrow[1]);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            checkOutput("ovf8",    ovf0,    eOvf[0]);
            checkOutput("ovf1",    ovf1,    eOvf[1]);
`endif
        end
    end

    function automatic logic doneOf(input int d);
        return (d == 0) ? done0 : done1;
    endfunction

    task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #2;
        startIn[d] = 1'b1; aIn[d] = a; bIn[d] = b;
        @(posedge clk); #2;
        startIn[d] = 1'b0; aIn[d] = 8'($urandom); bIn[d] = 8'($urandom);
    endtask

    // Latency counts edges after the sampling edge until o_done is seen high.
    task automatic waitDone(input int d, output int lat);
        bit seen = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (doneOf(d)) begin
                seen = 1'b1;
                lat = n;
            end
        end
        if (!seen) begin
            checks++;
            $display("[TB] FAIL done_timeout: no o_done on dut %0d, expected within 40 cycles", d);
        end
    endtask

    initial begin
        int lat;
        int doneCnt;
        logic ba, bb;
        rstN = 1'b0;
        for (int d = 0; d < 2; d++) begin
            startIn[d] = 1'b0; aIn[d] = '0; bIn[d] = '0;
        end
        running = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_done", done0, 0);
        checkOutput("rst_diff", diff0, 0);
        checkOutput("rst_borrow", borrow0, 0);
        #2 rstN = 1'b1;

        applyStimulus(0, 8'h5A, 8'h23);
        waitDone(0, lat);
        checkOutput("lat_5A_23", lat, 9);
        checkOutput("diff_5A_23", diff0, 8'h37);
        checkOutput("borrow_5A_23", borrow0, 0);

        applyStimulus(0, 8'h10, 8'h20);
        waitDone(0, lat);
        checkOutput("diff_10_20", diff0, 8'hF0);
        checkOutput("borrow_10_20", borrow0, 1);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checkOutput("ovf_10_20", ovf0, 0);
`endif

        applyStimulus(0, 8'h80, 8'h01);
        waitDone(0, lat);
        checkOutput("diff_80_01", diff0, 8'h7F);
        checkOutput("borrow_80_01", borrow0, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checkOutput("ovf_80_01", ovf0, 1);
`endif

        // Second start in RUN cycle 3 must be ignored.
        applyStimulus(0, 8'h5A, 8'h23);
        @(posedge clk); #2;
        startIn[0] = 1'b1; aIn[0] = 8'hFF; bIn[0] = 8'h01;
        @(posedge clk); #2;
        startIn[0] = 1'b0;
        waitDone(0, lat);
        checkOutput("diff_ignored_start", diff0, 8'h37);
        doneCnt = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (done0) doneCnt++;
        end
        checkOutput("extra_done_count", doneCnt, 0);
        checkOutput("diff_held", diff0, 8'h37);

        // Reset in RUN cycle 4 aborts the operation.
        applyStimulus(0, 8'h5A, 8'h23);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        checkOutput("abort_busy", busy0, 0);
        checkOutput("abort_done", done0, 0);
        checkOutput("abort_diff", diff0, 0);
        checkOutput("abort_borrow", borrow0, 0);
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        applyStimulus(0, 8'hFF, 8'hFF);
        waitDone(0, lat);
        checkOutput("lat_FF_FF", lat, 9);
        checkOutput("diff_FF_FF", diff0, 8'h00);
        checkOutput("borrow_FF_FF", borrow0, 0);

        for (int i = 0; i < 4; i++) begin
            ba = i[1];
            bb = i[0];
            applyStimulus(1, {7'b0, ba}, {7'b0, bb});
            waitDone(1, lat);
            checkOutput("lat_w1", lat, 2);
            checkOutput("diff_w1", diff1, ba ^ bb);
            checkOutput("borrow_w1", borrow1, ~ba & bb);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            checkOutput("ovf_w1", ovf1, (ba != bb) && ((ba ^ bb) != ba));
`endif
        end

        for (int c = 0; c < 900; c++) begin
            @(posedge clk); #2;
            for (int d = 0; d < 2; d++) begin
                startIn[d] = ($urandom_range(0, 3) == 0);
                aIn[d] = 8'($urandom);
                bIn[d] = 8'($urandom);
            end
            if (c == 450) begin
                #1 rstN = 1'b0;
                @(posedge clk);
                #3 rstN = 1'b1;
            end
        end
        startIn[0] = 1'b0;
        startIn[1] = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        running = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 1..64.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port i_start, input, 1, request to load operands; sampled only in IDLE.
REQ-005 SHALL have port i_a, input, WIDTH, minuend; sampled with i_start.
REQ-006 SHALL have port i_b, input, WIDTH, subtrahend; sampled with i_start.
REQ-007 SHALL have port o_busy, output, 1, high while in RUN.
REQ-008 SHALL have port o_done, output, 1, one-cycle pulse when the result becomes valid.
REQ-009 SHALL have port o_diff, output, WIDTH, registered result i_a - i_b modulo 2^WIDTH.
REQ-010 SHALL have port o_borrow, output, 1, final borrow-out; 1 exactly when unsigned i_a < i_b.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 In IDLE with i_start=1, SHALL capture i_a and i_b into shift registers, clear the borrow flop and the bit counter, and go to RUN.
REQ-013 In RUN, SHALL process one bit per cycle, LSB first: diff_bit = a^b^borrow; borrow_next = (~a&b) | (~a&borrow) | (b&borrow).
REQ-014 In RUN, SHALL shift each diff_bit into the result register from the MSB end, so that bit k sits at o_diff[k] after WIDTH shifts.
REQ-015 SHALL stay in RUN for exactly WIDTH cycles, then go to DONE; the counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap.
REQ-016 In DONE, SHALL assert o_done for one cycle, load o_borrow with the final borrow, and return to IDLE.
REQ-017 Latency SHALL be WIDTH+1 cycles from the i_start sampling edge to the o_done-high cycle.
REQ-018 o_diff and o_borrow SHALL hold their values until the next DONE.
REQ-019 i_start while in RUN or DONE SHALL be ignored; the operation in flight SHALL NOT be disturbed.
REQ-020 i_start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; i_start SHALL be accepted on the following IDLE cycle.
REQ-021 Changes on i_a and i_b after capture SHALL NOT affect the result.

Reset
REQ-022 While i_rst_n=0: state SHALL be IDLE; o_busy=0, o_done=0, o_diff=0, o_borrow=0; counter, shift registers and borrow flop SHALL be 0.
REQ-023 Reset during RUN SHALL abort the operation with no o_done pulse; the first i_start after release SHALL start a fresh operation.

Configuration
REQ-024 Macro SERIAL_SUBTRACTOR_OVF_EN SHALL control a signed-overflow feature.
REQ-025 With SERIAL_SUBTRACTOR_OVF_EN defined, SHALL add output o_ovf (1 bit, reset 0, updated in DONE): o_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-026 With SERIAL_SUBTRACTOR_OVF_EN undefined, the o_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_subtractor_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 The per-bit difference and borrow logic SHALL be the combinational sub-module full_subtractor (inputs i_a, i_b, i_bin; outputs o_diff, o_bout), instantiated once.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x23, start -> o_done on cycle 9; o_diff=0x37, o_borrow=0.
REQ-030 WIDTH=8, a=0x10, b=0x20 -> o_diff=0xF0, o_borrow=1; with OVF_EN, o_ovf=0.
REQ-031 WIDTH=8, OVF_EN, a=0x80, b=0x01 -> o_diff=0x7F, o_borrow=0, o_ovf=1.
REQ-032 Pulse i_start again at cycle 3 of RUN with new operands -> ignored; first result unchanged; exactly one o_done.
REQ-033 Drop i_rst_n at cycle 4 of RUN -> all outputs 0 immediately; no o_done; next start with a=b=0xFF -> o_diff=0x00, o_borrow=0.
REQ-034 WIDTH=1, all four (a,b) combinations -> o_done 2 cycles after start; results match the 1-bit truth table.
